phy_reg_free_list: RTL and testbench
====================================

Name: phy_reg_free_list

Overview:
Physical-register free list for the rename stage. It is the consumer end of the commit-side release protocol: it accepts physical registers freed at commit or recovery (releaseReg / phyReleasedReg, up to COMMIT_WIDTH per cycle). It is also the producer end of rename allocation: it supplies phyDstReg and allocatable to the rename stage, up to RENAME_WIDTH per cycle. Storage is a circular FIFO of FREE_NUM = PREG_NUM - LREG_NUM entries, filled by an init sweep after reset.

Parameters:
PREG_NUM, 64, number of physical registers; PREG_W = clog2(PREG_NUM)
LREG_NUM, 32, number of logical registers; physical regs 0..LREG_NUM-1 are initially mapped and are never in the list after init
RENAME_WIDTH, 2, allocation lanes per cycle
COMMIT_WIDTH, 2, release lanes per cycle

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
rstStart  in  1  one-cycle pulse that starts the init sweep
allocReq  in  RENAME_WIDTH  per-lane allocate request (writeReg & updateRMT)
allocatable  out  1  at least RENAME_WIDTH free entries and state==RUN
phyDstReg  out  RENAME_WIDTH x PREG_W  register granted to each lane
releaseReg  in  COMMIT_WIDTH  per-lane release valid
phyReleasedReg  in  COMMIT_WIDTH x PREG_W  register released per lane
freeCount  out  clog2(FREE_NUM+1)  current number of free entries
initDone  out  1  high in RUN state
errSticky  out  1  sticky protocol-violation flag

Behaviour:
- Reset (rst low, asynchronous): state=WAIT, head=0, tail=0, count=0, initPtr=0, errSticky=0. All outputs read 0: allocatable=0, initDone=0, freeCount=0, phyDstReg=0. Reset mid-sweep or mid-run discards all contents immediately.
- FSM:
  - WAIT --rstStart--> INIT.
  - INIT writes entry[initPtr] = LREG_NUM + initPtr, one per cycle, and increments initPtr. After the write with initPtr == FREE_NUM-1: count=FREE_NUM, head=0, tail=0, go to RUN. The sweep takes exactly FREE_NUM cycles.
  - RUN --rstStart--> INIT: clear head, tail, count and initPtr, and restart the sweep. errSticky is not cleared.
- Allocation (RUN only), combinational read:
  - Lane i receives entry[(head + k) mod FREE_NUM], where k = number of requesting lanes below i. Granted registers are therefore compacted and in FIFO order.
  - phyDstReg is valid in the same cycle as allocReq. At the clock edge, head advances by popcount(allocReq), mod FREE_NUM.
  - Non-requesting lanes drive the value lane i would have received, which is don't-care for the consumer.
- allocatable = (state==RUN) && (count >= RENAME_WIDTH). The value is registered-state based, with no same-cycle dependence on releases.
- Release (RUN only):
  - Valid lanes are compacted and written at tail + j, where j = valid lanes below. tail advances by popcount(releaseReg), mod FREE_NUM.
  - A register released in cycle t becomes allocatable from cycle t+1 at the earliest. There is no bypass.
- Count: count_next = count + nRel - nAlloc, evaluated in the same cycle. Simultaneous alloc and release at any fill level, including full and empty, are legal as long as the result stays within 0..FREE_NUM.
- Wrap-around: pointer arithmetic uses explicit compare-and-subtract, so FREE_NUM need not be a power of 2. Lanes in one cycle may straddle the wrap point.
- Violations set errSticky; it clears only on reset.
  - Any allocReq while allocatable==0: all requests that cycle are ignored; head and count are unchanged.
  - Any releaseReg outside RUN: the releases are dropped.
  - count + nRel - nAlloc > FREE_NUM: lanes are accepted in lane order up to capacity and the excess is dropped.
- freeCount = count (registered).

Test Plan:
- Init: reset low→high, rstStart pulse → initDone after 32 cycles; freeCount=32; first alloc of 2 lanes gives phyDstReg={32,33}.
- Compaction: RUN with allocReq=2'b10 → lane1 gets 32; next cycle allocReq=2'b11 → {33,34}; freeCount 32→31→29.
- Drain/empty: allocate 2/cycle for 15 cycles → freeCount=2, allocatable=1; one more → freeCount=0, allocatable=0; an allocReq now → errSticky=1, freeCount stays 0.
- Release and wrap: from freeCount=0 with head=tail=0, release {5,7} → freeCount=2 next cycle, allocatable=1; alloc 2 → {5,7}. Fill until tail straddles index 31→0 and check FIFO order across the wrap.
- Simultaneous: at freeCount=32 (full), alloc 2 and release 2 in the same cycle → freeCount stays 32, no error; the released regs appear only after the other 30 entries are consumed.
- Reset mid-sweep: pull rst low at INIT cycle 10 → all outputs 0 immediately; a new rstStart → a full 32-cycle sweep, contents again 32..63.

Source files
------------

// File: rtl/phy_reg_free_list.sv
// rtl/phy_reg_free_list.sv - rename-stage physical register free list
// Circular FIFO of free physical registers, seeded by an init sweep, drained by rename, refilled by commit.
module phy_reg_free_list #(
  parameter int PREG_NUM     = 64,
  parameter int LREG_NUM     = 32,
  parameter int RENAME_WIDTH = 2,
  parameter int COMMIT_WIDTH = 2,
  localparam int PREG_W      = $clog2(PREG_NUM),
  localparam int FREE_NUM    = PREG_NUM - LREG_NUM,
  localparam int CNT_W       = $clog2(FREE_NUM + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   rstStart,
  input  logic [RENAME_WIDTH-1:0]                allocReq,
  output logic                                   allocatable,
  output logic [RENAME_WIDTH-1:0][PREG_W-1:0]    phyDstReg,
  input  logic [COMMIT_WIDTH-1:0]                releaseReg,
  input  logic [COMMIT_WIDTH-1:0][PREG_W-1:0]    phyReleasedReg,
  output logic [CNT_W-1:0]                       freeCount,
  output logic                                   initDone,
  output logic                                   errSticky
);

  localparam int PTR_W = (FREE_NUM > 1) ? $clog2(FREE_NUM) : 1;

  typedef enum logic [1:0] {S_WAIT, S_INIT, S_RUN} state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W-1:0]  init_ptr_q, init_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;
  logic [PREG_W-1:0] mem_q [FREE_NUM];
  logic [PREG_W-1:0] mem_d [FREE_NUM];

  // Compare-and-subtract wrap so FREE_NUM need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= FREE_NUM) s = s - FREE_NUM;
    return PTR_W'(s);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_WAIT;
      head_q     <= '0;
      tail_q     <= '0;
      init_ptr_q <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      init_ptr_q <= init_ptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:  if (rstStart) state_d = S_INIT;
      S_INIT:  if (init_ptr_q == PTR_W'(FREE_NUM - 1)) state_d = S_RUN;
      S_RUN:   if (rstStart) state_d = S_INIT;
      default: state_d = S_WAIT;
    endcase
  end

  // Grants are compacted: lane i takes the entry after those handed to lower requesting lanes.
  always_comb begin
    int k;
    k           = 0;
    initDone    = (state_q == S_RUN);
    allocatable = initDone && (int'(count_q) >= RENAME_WIDTH);
    freeCount   = count_q;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      phyDstReg[i] = initDone ? mem_q[ptr_add(head_q, k)] : '0;
      if (allocReq[i]) k = k + 1;
    end
  end

  always_comb begin
    int n_alloc;
    int n_rel;
    int cap;
    head_d     = head_q;
    tail_d     = tail_q;
    init_ptr_d = init_ptr_q;
    count_d    = count_q;
    err_d      = err_q;
    mem_d      = mem_q;
    n_alloc    = 0;
    n_rel      = 0;
    cap        = 0;

    if (|allocReq && !allocatable) err_d = 1'b1;

    case (state_q)
      S_INIT: begin
        mem_d[init_ptr_q] = PREG_W'(LREG_NUM + int'(init_ptr_q));
        if (init_ptr_q == PTR_W'(FREE_NUM - 1)) begin
          init_ptr_d = '0;
          head_d     = '0;
          tail_d     = '0;
          count_d    = CNT_W'(FREE_NUM);
        end else begin
          init_ptr_d = init_ptr_q + 1'b1;
        end
        if (|releaseReg) err_d = 1'b1;
      end
      S_RUN: begin
        if (rstStart) begin
          head_d     = '0;
          tail_d     = '0;
          count_d    = '0;
          init_ptr_d = '0;
        end else begin
          if (allocatable) begin
            for (int i = 0; i < RENAME_WIDTH; i++) begin
              if (allocReq[i]) n_alloc = n_alloc + 1;
            end
          end
          // Releases beyond the room left after this cycle's allocations are dropped in lane order.
          cap = FREE_NUM - int'(count_q) + n_alloc;
          for (int j = 0; j < COMMIT_WIDTH; j++) begin
            if (releaseReg[j]) begin
              if (n_rel < cap) begin
                mem_d[ptr_add(tail_q, n_rel)] = phyReleasedReg[j];
                n_rel = n_rel + 1;
              end else begin
                err_d = 1'b1;
              end
            end
          end
          head_d  = ptr_add(head_q, n_alloc);
          tail_d  = ptr_add(tail_q, n_rel);
          count_d = CNT_W'(int'(count_q) + n_rel - n_alloc);
        end
      end
      default: begin
        if (|releaseReg) err_d = 1'b1;
      end
    endcase
  end

  assign errSticky = err_q;

endmodule

// File: tb/tb_phy_reg_free_list.sv
// tb/tb_phy_reg_free_list.sv - directed vector bench for phy_reg_free_list
module tb_phy_reg_free_list;

  logic            clk = 1'b0;
  logic            rst;
  logic            rstStart;
  logic [1:0]      allocReq;
  logic            allocatable;
  logic [1:0][5:0] phyDstReg;
  logic [1:0]      releaseReg;
  logic [1:0][5:0] phyReleasedReg;
  logic [5:0]      freeCount;
  logic            initDone;
  logic            errSticky;

  int total = 0;
  int bad   = 0;

  phy_reg_free_list dut (
    .clk            (clk),
    .rst            (rst),
    .rstStart       (rstStart),
    .allocReq       (allocReq),
    .allocatable    (allocatable),
    .phyDstReg      (phyDstReg),
    .releaseReg     (releaseReg),
    .phyReleasedReg (phyReleasedReg),
    .freeCount      (freeCount),
    .initDone       (initDone),
    .errSticky      (errSticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] alloc;
    logic [1:0] rel;
    logic [5:0] r0;
    logic [5:0] r1;
    logic       alc;
    logic [1:0] mask;
    logic [5:0] d0;
    logic [5:0] d1;
    logic [5:0] cnt;
    logic       err;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input int alloc, input int rel, input int r0, input int r1,
                              input int alc, input int mask, input int d0, input int d1,
                              input int cnt, input int err);
    vec_t v;
    v.alloc = 2'(alloc);
    v.rel   = 2'(rel);
    v.r0    = 6'(r0);
    v.r1    = 6'(r1);
    v.alc   = 1'(alc);
    v.mask  = 2'(mask);
    v.d0    = 6'(d0);
    v.d1    = 6'(d1);
    v.cnt   = 6'(cnt);
    v.err   = 1'(err);
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (!initDone && n < 40) begin
      tick();
      n++;
    end
    chk(name, n, 32);
  endtask

  initial begin
    rst            = 1'b0;
    rstStart       = 1'b0;
    allocReq       = '0;
    releaseReg     = '0;
    phyReleasedReg = '0;
    repeat (2) tick();
    chk("rst allocatable", allocatable, 0);
    chk("rst initDone", initDone, 0);
    chk("rst freeCount", freeCount, 0);
    chk("rst phyDstReg", phyDstReg, 0);
    chk("rst errSticky", errSticky, 0);

    rst = 1'b1;
    tick();
    rstStart = 1'b1;
    tick();
    rstStart = 1'b0;
    chk("init busy initDone", initDone, 0);
    wait_init("init cycles");
    chk("init freeCount", freeCount, 32);
    chk("init allocatable", allocatable, 1);

    // Compaction, then drain to empty and a violating request.
    add(2, 0, 0, 0, 1, 2, 0, 32, 32, 0);
    add(3, 0, 0, 0, 1, 3, 33, 34, 31, 0);
    add(1, 0, 0, 0, 1, 1, 35, 0, 29, 0);
    for (int m = 0; m < 13; m++) add(3, 0, 0, 0, 1, 3, 36 + 2*m, 37 + 2*m, 28 - 2*m, 0);
    add(3, 0, 0, 0, 1, 3, 62, 63, 2, 0);
    add(3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Release from empty, then fill and drain across the wrap point on both pointers.
    add(0, 3, 5, 7, 0, 0, 0, 0, 0, 1);
    add(3, 0, 0, 0, 1, 3, 5, 7, 2, 1);
    add(0, 2, 0, 10, 0, 0, 0, 0, 0, 1);
    for (int m = 0; m < 14; m++) add(0, 3, 11 + 2*m, 12 + 2*m, (m > 0) ? 1 : 0, 0, 0, 0, 1 + 2*m, 1);
    add(0, 3, 39, 40, 1, 0, 0, 0, 29, 1);
    add(1, 0, 0, 0, 1, 1, 10, 0, 31, 1);
    for (int m = 0; m < 14; m++) add(3, 0, 0, 0, 1, 3, 11 + 2*m, 12 + 2*m, 30 - 2*m, 1);
    add(3, 0, 0, 0, 1, 3, 39, 40, 2, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Fill to full, then simultaneous alloc and release at full.
    for (int k = 0; k < 16; k++) add(0, 3, 2*k + 1, 2*k + 2, (k >= 1) ? 1 : 0, 0, 0, 0, 2*k, 1);
    add(3, 3, 50, 51, 1, 3, 1, 2, 32, 1);
    for (int m = 0; m < 15; m++) add(3, 0, 0, 0, 1, 3, 3 + 2*m, 4 + 2*m, 32 - 2*m, 1);
    add(3, 0, 0, 0, 1, 3, 50, 51, 2, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    for (int n = 0; n < vq.size(); n++) begin
      allocReq          = vq[n].alloc;
      releaseReg        = vq[n].rel;
      phyReleasedReg[0] = vq[n].r0;
      phyReleasedReg[1] = vq[n].r1;
      #1;
      chk($sformatf("v%0d allocatable", n), allocatable, vq[n].alc);
      chk($sformatf("v%0d freeCount", n), freeCount, vq[n].cnt);
      chk($sformatf("v%0d errSticky", n), errSticky, vq[n].err);
      if (vq[n].mask[0]) chk($sformatf("v%0d dst0", n), phyDstReg[0], vq[n].d0);
      if (vq[n].mask[1]) chk($sformatf("v%0d dst1", n), phyDstReg[1], vq[n].d1);
      tick();
    end
    allocReq       = '0;
    releaseReg     = '0;
    phyReleasedReg = '0;

    // Restart from RUN, then async reset in the middle of the sweep.
    rstStart = 1'b1;
    tick();
    rstStart = 1'b0;
    repeat (10) tick();
    chk("sweep initDone", initDone, 0);
    rst = 1'b0;
    #1;
    chk("midrst allocatable", allocatable, 0);
    chk("midrst initDone", initDone, 0);
    chk("midrst freeCount", freeCount, 0);
    chk("midrst phyDstReg", phyDstReg, 0);
    chk("midrst errSticky", errSticky, 0);
    rst = 1'b1;
    tick();
    rstStart = 1'b1;
    tick();
    rstStart = 1'b0;
    wait_init("resweep cycles");
    chk("resweep freeCount", freeCount, 32);
    for (int k = 0; k < 16; k++) begin
      allocReq = 2'b11;
      #1;
      chk($sformatf("resweep dst0 k%0d", k), phyDstReg[0], 32 + 2*k);
      chk($sformatf("resweep dst1 k%0d", k), phyDstReg[1], 33 + 2*k);
      tick();
    end
    allocReq = '0;
    #1;
    chk("resweep empty", freeCount, 0);
    chk("resweep errSticky", errSticky, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
